// File: rtl/servo_pkg.sv
// Shared constants, state enums and duty-range helpers for the servo command receiver.
package servo_pkg;

  localparam int unsigned DUTY_W = 32;
  localparam logic [7:0] SERVO_HEADER = 8'hA5;
  localparam logic [7:0] MAX_ANGLE = 8'd180;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  typedef enum logic {
    WAIT_HDR,
    WAIT_ANG
  } frame_state_e;

  function automatic logic [DUTY_W-1:0] duty_min(input logic [DUTY_W-1:0] period);
    return period * 32'd5 / 32'd100;
  endfunction

  function automatic logic [DUTY_W-1:0] duty_max(input logic [DUTY_W-1:0] period);
    return period * 32'd10 / 32'd100;
  endfunction

  function automatic logic [DUTY_W-1:0] duty_step(input logic [DUTY_W-1:0] period);
    return (duty_max(period) - duty_min(period)) / 32'd180;
  endfunction

endpackage

// File: rtl/servo_cmd_rx_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, byte_valid / stop_err pulses.
module uart_rx
  import servo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  logic             rx_prev_q;
  uart_state_e      state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       bit_q, bit_n;
  logic [7:0]       shreg_q, shreg_n;
  logic [7:0]       data_n;
  logic             byte_valid_n, stop_err_n;

  assign rx_s = sync_q[1];

  // Synchronizer resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      state_q    <= U_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      rx_prev_q  <= rx_s;
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      bit_q      <= bit_n;
      shreg_q    <= shreg_n;
      data       <= data_n;
      byte_valid <= byte_valid_n;
      stop_err   <= stop_err_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    bit_n        = bit_q;
    shreg_n      = shreg_q;
    data_n       = data;
    byte_valid_n = 1'b0;
    stop_err_n   = 1'b0;
    case (state_q)
      U_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (rx_prev_q && !rx_s) state_n = U_START;
      end
      U_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_n   = '0;
          state_n = rx_s ? U_IDLE : U_DATA;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      U_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg_q[7:1]};
          if (bit_q == 3'd7) state_n = U_STOP;
          else bit_n = bit_q + 3'd1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      U_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_n   = '0;
          state_n = U_IDLE;
          if (rx_s) begin
            data_n       = shreg_q;
            byte_valid_n = 1'b1;
          end else begin
            stop_err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = U_IDLE;
    endcase
  end

endmodule

// File: rtl/servo_cmd_rx.sv
// Servo command receiver: validates A5/angle frames from UART and converts angle to PWM duty.
// Optional rate-limited duty update per PWM period when SERVO_SLEW_EN is defined.
module servo_cmd_rx
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 25_000_000,
  parameter int unsigned BAUD           = 115_200,
  parameter int unsigned PERIOD         = 500_000,
  parameter logic [7:0]  HEADER         = SERVO_HEADER,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned SLEW_STEP      = 500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  output logic [DUTY_W-1:0]   duty_cycle,
  output logic                cmd_valid,
  output logic                frame_err,
  output logic [7:0]          angle
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [DUTY_W-1:0] DMIN = duty_min(DUTY_W'(PERIOD));
  localparam logic [DUTY_W-1:0] DMAX = duty_max(DUTY_W'(PERIOD));
  localparam logic [DUTY_W-1:0] STEP = duty_step(DUTY_W'(PERIOD));
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_M1 = TO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0]        rx_byte;
  logic              rx_valid, rx_stop_err;
  frame_state_e      fstate_q, fstate_n;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_n;
  logic [DUTY_W-1:0] target_q, target_n, duty_n, conv_duty;
  logic [7:0]        angle_n;
  logic              accept, err_n;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (rx_byte),
    .byte_valid(rx_valid),
    .stop_err  (rx_stop_err)
  );

  // 180 degrees is pinned to DUTY_MAX; truncated STEP would otherwise fall short.
  assign conv_duty = (rx_byte == MAX_ANGLE) ? DMAX : DMIN + DUTY_W'(rx_byte) * STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate_q   <= WAIT_HDR;
      to_cnt_q   <= '0;
      target_q   <= DMIN;
      duty_cycle <= DMIN;
      angle      <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      fstate_q   <= fstate_n;
      to_cnt_q   <= to_cnt_n;
      target_q   <= target_n;
      duty_cycle <= duty_n;
      angle      <= angle_n;
      cmd_valid  <= accept;
      frame_err  <= err_n;
    end
  end

  always_comb begin
    fstate_n = fstate_q;
    to_cnt_n = to_cnt_q;
    accept   = 1'b0;
    err_n    = rx_stop_err;
    case (fstate_q)
      WAIT_HDR: begin
        to_cnt_n = '0;
        if (rx_valid && rx_byte == HEADER) fstate_n = WAIT_ANG;
      end
      WAIT_ANG: begin
        if (rx_valid) begin
          fstate_n = WAIT_HDR;
          if (rx_byte <= MAX_ANGLE) accept = 1'b1;
          else err_n = 1'b1;
        end else if (rx_stop_err) begin
          fstate_n = WAIT_HDR;
        end else if (to_cnt_q == TO_M1) begin
          fstate_n = WAIT_HDR;
          err_n    = 1'b1;
        end else begin
          to_cnt_n = to_cnt_q + TO_W'(1);
        end
      end
      default: fstate_n = WAIT_HDR;
    endcase
    target_n = accept ? conv_duty : target_q;
    angle_n  = accept ? rx_byte : angle;
  end

`ifdef SERVO_SLEW_EN
  localparam int unsigned PER_W = $clog2(PERIOD + 1);
  localparam logic [DUTY_W-1:0] SLEW = DUTY_W'(SLEW_STEP);

  logic [PER_W-1:0] per_q;
  logic             wrap;

  assign wrap = (per_q == PER_W'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) per_q <= '0;
    else        per_q <= wrap ? '0 : per_q + PER_W'(1);
  end

  // Move toward target by at most SLEW once per PWM period, clamping at target.
  always_comb begin
    duty_n = duty_cycle;
    if (wrap) begin
      if (target_q > duty_cycle)
        duty_n = (target_q - duty_cycle > SLEW) ? duty_cycle + SLEW : target_q;
      else if (target_q < duty_cycle)
        duty_n = (duty_cycle - target_q > SLEW) ? duty_cycle - SLEW : target_q;
    end
  end
`else
  always_comb begin
    duty_n = accept ? conv_duty : duty_cycle;
  end
`endif

endmodule

// File: tb/tb_servo_cmd_rx.sv
// Directed plus randomized frame bench for servo_cmd_rx (default build, fast baud and short timeout).
module tb_servo_cmd_rx;

  localparam int unsigned CLK_FREQ = 25_000_000;
  localparam int unsigned BAUD     = 1_562_500;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int unsigned PERIOD   = 500_000;
  localparam int unsigned TIMEOUT  = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [31:0] duty_cycle;
  logic        cmd_valid, frame_err;
  logic [7:0]  angle;

  int tests = 0;
  int fails = 0;
  int cmd_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [31:0] pulse_duty = '0;
  logic [7:0]  pulse_angle = '0;

  servo_cmd_rx #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUD          (BAUD),
    .PERIOD        (PERIOD),
    .HEADER        (8'hA5),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SLEW_STEP     (500)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .duty_cycle(duty_cycle),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err),
    .angle     (angle)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) begin
        cmd_cnt++;
        pulse_duty  = duty_cycle;
        pulse_angle = angle;
      end
      if (frame_err) err_cnt++;
      if (cmd_valid && frame_err) both_cnt++;
    end
  end

  function automatic logic [31:0] model_duty(input int unsigned a);
    int unsigned dmin, dmax;
    dmin = PERIOD * 5 / 100;
    dmax = PERIOD * 10 / 100;
    if (a == 180) return dmax;
    return dmin + a * ((dmax - dmin) / 180);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] a);
    send_byte(h, 1'b1);
    idle(4);
    send_byte(a, 1'b1);
    idle(10);
  endtask

  int c0, e0;
  int unsigned ang;
  logic [7:0] hdr;
  logic [31:0] exp_duty;
  logic [7:0]  exp_angle;
  bit hdr_ok;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_duty", duty_cycle, 32'd25000);
    chk("reset_angle", 32'(angle), 32'd0);
    chk("reset_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    idle(2000);
    chk("idle_no_cmd", 32'(cmd_cnt), 32'd0);
    chk("idle_no_err", 32'(err_cnt), 32'd0);

    c0 = cmd_cnt;
    send_frame(8'hA5, 8'h5A);
    chk("a90_cmd_pulses", 32'(cmd_cnt - c0), 32'd1);
    chk("a90_duty", duty_cycle, 32'd37420);
    chk("a90_duty_at_pulse", pulse_duty, 32'd37420);
    chk("a90_angle", 32'(angle), 32'd90);

    send_frame(8'hA5, 8'hB4);
    chk("a180_duty", duty_cycle, 32'd50000);
    chk("a180_angle_at_pulse", 32'(pulse_angle), 32'd180);
    send_frame(8'hA5, 8'h00);
    chk("a0_duty", duty_cycle, 32'd25000);

    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'hA5, 8'hC8);
    chk("a200_err", 32'(err_cnt - e0), 32'd1);
    chk("a200_no_cmd", 32'(cmd_cnt - c0), 32'd0);
    chk("a200_duty_kept", duty_cycle, 32'd25000);

    c0 = cmd_cnt;
    send_frame(8'hA5, 8'hA5);
    chk("hdr_as_angle_cmd", 32'(cmd_cnt - c0), 32'd1);
    chk("hdr_as_angle_duty", duty_cycle, model_duty(165));
    chk("hdr_as_angle_angle", 32'(angle), 32'd165);
    send_frame(8'hA5, 8'h00);

    e0 = err_cnt; c0 = cmd_cnt;
    send_byte(8'hA5, 1'b1);
    idle(TIMEOUT - 300);
    chk("timeout_not_early", 32'(err_cnt - e0), 32'd0);
    idle(500);
    chk("timeout_err", 32'(err_cnt - e0), 32'd1);
    send_byte(8'h5A, 1'b1);
    idle(10);
    chk("lone_angle_no_cmd", 32'(cmd_cnt - c0), 32'd0);
    chk("lone_angle_duty", duty_cycle, 32'd25000);

    e0 = err_cnt; c0 = cmd_cnt;
    send_byte(8'h3C, 1'b0);
    idle(CPB * 2);
    chk("stop_bit_err", 32'(err_cnt - e0), 32'd1);

    e0 = err_cnt; c0 = cmd_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(CPB * 12);
    chk("glitch_no_err", 32'(err_cnt - e0), 32'd0);
    chk("glitch_no_cmd", 32'(cmd_cnt - c0), 32'd0);

    send_frame(8'hA5, 8'h5A);
    chk("pre_reset_duty", duty_cycle, 32'd37420);
    send_byte(8'hA5, 1'b1);
    idle(4);
    rx = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midbyte_reset_duty", duty_cycle, 32'd25000);
    chk("midbyte_reset_angle", 32'(angle), 32'd0);
    idle(CPB * 12);
    send_frame(8'hA5, 8'hB4);
    chk("post_reset_duty", duty_cycle, 32'd50000);
    chk("post_reset_angle", 32'(angle), 32'd180);

    exp_duty  = duty_cycle === 32'd50000 ? 32'd50000 : model_duty(180);
    exp_angle = 8'd180;
    for (int k = 0; k < 14; k++) begin
      hdr_ok = ($urandom_range(0, 3) != 0);
      ang    = $urandom_range(0, 255);
      if (hdr_ok) begin
        hdr = 8'hA5;
      end else begin
        hdr = 8'($urandom_range(0, 255));
        if (hdr == 8'hA5) hdr = 8'h5A;
        if (ang == 32'hA5) ang = 32'h11;
      end
      c0 = cmd_cnt; e0 = err_cnt;
      send_byte(hdr, 1'b1);
      idle($urandom_range(1, 40));
      send_byte(8'(ang), 1'b1);
      idle(10);
      if (hdr_ok && ang <= 180) begin
        exp_duty  = model_duty(ang);
        exp_angle = 8'(ang);
      end
      chk("rand_cmd", 32'(cmd_cnt - c0), (hdr_ok && ang <= 180) ? 32'd1 : 32'd0);
      chk("rand_err", 32'(err_cnt - e0), (hdr_ok && ang > 180) ? 32'd1 : 32'd0);
      chk("rand_duty", duty_cycle, exp_duty);
      chk("rand_angle", 32'(angle), 32'(exp_angle));
    end

    chk("cmd_err_exclusive", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
